// File: rtl/dmem_bridge.sv
// Data-memory bridge: routes datapath loads/stores to a 1-cycle synchronous RAM or to MMIO registers.
// RAM loads take 3 cycles (Stall high for 2); RAM stores and MMIO accesses complete in 1 cycle with no stall.
module dmem_bridge #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [31:0]   Addr,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          AddrErr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic [7:0]    led_out
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_cycles;
    logic [31:0]   r_rdata;
    logic [7:0]    r_led;
    logic          r_err;
    logic [AW-1:0] r_ld_addr;

    logic          w_in_ram, w_is_led, w_is_cyc, w_is_stat, w_aligned, w_ok;
    logic          w_idle, w_wr, w_rd, w_bad, w_ram_rd;
    logic [AW-1:0] w_word;
    logic [31:0]   w_mmio_rdata;

    assign w_in_ram  = {1'b0, Addr} < RAM_BYTES;
    assign w_is_led  = Addr == MMIO_BASE;
    assign w_is_cyc  = Addr == (MMIO_BASE + 32'd4);
    assign w_is_stat = Addr == (MMIO_BASE + 32'd8);
    assign w_aligned = Addr[1:0] == 2'b00;
    assign w_ok      = w_aligned && (w_in_ram || w_is_led || w_is_cyc || w_is_stat);
    assign w_word    = Addr[AW+1:2];

    // Requests are only accepted in IDLE; the held request during RD_WAIT/RD_DONE is the load already in progress.
    assign w_idle    = reset && (r_state == IDLE);
    assign w_wr      = w_idle && MemWrite;
    assign w_rd      = w_idle && MemRead && !MemWrite;
    assign w_bad     = (w_wr || w_rd) && !w_ok;
    assign w_ram_rd  = w_rd && w_ok && w_in_ram;

    always_comb begin
        w_mmio_rdata = 32'd0;
        if (w_is_led)
            w_mmio_rdata = {24'd0, r_led};
        else if (w_is_cyc)
            w_mmio_rdata = r_cycles;
        else if (w_is_stat)
            w_mmio_rdata = {31'd0, r_err};
    end

    always_comb begin
        w_next   = r_state;
        Stall    = 1'b0;
        ram_we   = 1'b0;
        ReadData = 32'd0;
        ram_addr = w_word;
        case (r_state)
            IDLE: begin
                if (w_ram_rd) begin
                    Stall  = 1'b1;
                    w_next = RD_WAIT;
                end else if (w_rd && w_ok) begin
                    ReadData = w_mmio_rdata;
                end
                ram_we = w_wr && w_ok && w_in_ram;
            end
            RD_WAIT: begin
                ram_addr = r_ld_addr;
                Stall    = reset;
                w_next   = RD_DONE;
            end
            RD_DONE: begin
                ram_addr = r_ld_addr;
                ReadData = reset ? r_rdata : 32'd0;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cycles  <= 32'd0;
            r_rdata   <= 32'd0;
            r_led     <= 8'd0;
            r_err     <= 1'b0;
            r_ld_addr <= '0;
        end else begin
            r_state  <= w_next;
            r_cycles <= r_cycles + 32'd1;
            if (r_state == RD_WAIT)
                r_rdata <= ram_rdata;
            if (w_ram_rd)
                r_ld_addr <= w_word;
            if (w_wr && w_ok && w_is_led)
                r_led <= WriteData[7:0];
            // A new error takes priority over a W1C clear in the same cycle.
            if (w_bad)
                r_err <= 1'b1;
            else if (w_wr && w_ok && w_is_stat && WriteData[0])
                r_err <= 1'b0;
        end
    end

    assign ram_wdata = WriteData;
    assign AddrErr   = r_err;
    assign led_out   = r_led;
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle datapath's memory port.
- Takes the datapath's ALUResult (address), WriteData and the decoder's MemRead/MemWrite strobes.
- Returns ReadData, which feeds the datapath's result mux.
- Routes accesses to an external synchronous single-port data RAM (1-cycle read latency) or to a small MMIO register set, and raises Stall while a RAM load is in flight so the PC register and register file hold.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two); RAM region is byte addresses 0 .. DEPTH_WORDS*4-1
MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO block

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low; state cleared on a rising clk edge while reset=0
MemRead  input  1  load request from control unit
MemWrite  input  1  store request from control unit
Addr  input  32  byte address (datapath ALUResult)
WriteData  input  32  store data
ReadData  output  32  load data to datapath result mux
Stall  output  1  hold PC/register writes this cycle
AddrErr  output  1  sticky access-error flag
ram_addr  output  log2(DEPTH_WORDS)  RAM word address = Addr[log2(DEPTH_WORDS)+1:2]
ram_we  output  1  RAM write enable (RAM writes on clk edge)
ram_wdata  output  32  = WriteData
ram_rdata  input  32  RAM read data, valid the cycle after address is presented
led_out  output  8  MMIO LED register

Behaviour:
- Address map:
  - RAM: Addr < DEPTH_WORDS*4.
  - LED: MMIO_BASE+0. RW. Bits [7:0] are used; upper bits read 0.
  - CYCLES: MMIO_BASE+4. RO. Writes are ignored and do not flag an error.
  - STATUS: MMIO_BASE+8. Read returns {31'b0, AddrErr}. Writing bit0=1 clears AddrErr (W1C).
  - Any other address is unmapped.
- Error: an access is bad if Addr[1:0] != 0 or it is unmapped. On a bad access:
  - set AddrErr;
  - no RAM or register write occurs;
  - ReadData=0 and Stall=0.
  - If a W1C write and a new error occur in the same cycle, set wins.
- Simultaneous MemRead and MemWrite: treat as a write only.
- FSM states IDLE, RD_WAIT, RD_DONE:
  - IDLE, valid RAM read: Stall=1 (combinational) and ram_addr driven. Next state RD_WAIT.
  - RD_WAIT: Stall=1. Capture ram_rdata into the read-data register at the clock edge. Next state RD_DONE.
  - RD_DONE: Stall=0. ReadData = captured register. New requests are ignored in this cycle, since it is the same instruction completing. Next state IDLE.
  - Total RAM load occupancy is 3 cycles, with Stall high for 2.
- RAM store (IDLE, valid): ram_we=1 combinationally in that cycle, Stall=0, single cycle. State stays IDLE.
- MMIO reads: zero-wait. ReadData is driven combinationally in IDLE and Stall=0.
- MMIO writes: take effect at the clock edge of the request cycle.
- ram_we is 0 in every state other than IDLE.
- ReadData is 0 when no read is active.
- CYCLES: 32-bit counter, +1 every clock with reset=1, wraps FFFF_FFFF -> 0.
- Reset (reset=0 at an edge):
  - state IDLE;
  - led_out=0, CYCLES=0, AddrErr=0, read-data register=0.
  - While reset=0, Stall=0 and ram_we=0 regardless of inputs.
  - Reset during RD_WAIT or RD_DONE aborts the load with no capture; the first cycle after reset is IDLE.
- No request (MemRead=MemWrite=0): all outputs are idle values and state is unchanged.

Test Plan:
- Reset with MemRead=1 and Addr=0 held -> Stall=0, ram_we=0, led_out=0, AddrErr=0; after release, CYCLES reads 0 then 1 on consecutive zero-wait reads.
- Store 32'hDEADBEEF to Addr=0x10, then load 0x10 -> ram_we=1 for 1 cycle with ram_addr=4; load shows Stall=1,1,0 and ReadData=DEADBEEF in the third cycle; model RAM returns the stored word.
- Back-to-back loads 0x10 then 0x14 -> each takes 3 cycles with no overlap; the second ram_addr=5 appears only after RD_DONE.
- Write 0x1A5 to MMIO_BASE+0 -> led_out=0xA5 next cycle; read back 0x000000A5 with Stall=0.
- Load from Addr=0x13 (misaligned) and store to 0x8000_0000 (unmapped) -> AddrErr=1, ram_we never asserted, ReadData=0; write 1 to MMIO_BASE+8 -> AddrErr=0.
- Start load, assert reset=0 during RD_WAIT -> next cycle state IDLE, Stall=0, ReadData=0; force CYCLES to FFFF_FFFF -> next read 0.
